// File: rtl/chime_sequencer_pkg.sv
// chime_sequencer_pkg
//   Shared constants for the hourly chime sequencer and its helpers:
//   FSM state encoding and the BCD minute/second patterns that mark
//   the hour and half-hour boundaries.
package chime_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEEP = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [15:0] BCD_ZERO_MS  = 16'h0000;
  localparam logic [15:0] BCD_HALF_MS  = 16'h3000;
  localparam logic [7:0]  BCD_HOUR_MAX = 8'h23;

endpackage

// File: rtl/chime_sequencer_bcd_hour_to_count.sv
// bcd_hour_to_count
//   Combinational conversion of a 24-hour BCD hour into the number of
//   beeps shown on a 12-hour dial (00 -> 12, 13..23 -> 1..11).
//   Ports:
//     hour_bcd - in,  8 : BCD hour, 00..23
//     count    - out, 4 : 12-hour value 1..12 (0 when invalid)
//     valid    - out, 1 : both nibbles are decimal and hour <= 23
module bcd_hour_to_count
  import chime_sequencer_pkg::*;
(
  input  logic [7:0] hour_bcd,
  output logic [3:0] count,
  output logic       valid
);

  logic [7:0] hour_bin;
  logic [3:0] hour_minus12;

  always_comb begin
    hour_bin     = {4'd0, hour_bcd[7:4]} * 8'd10 + {4'd0, hour_bcd[3:0]};
    // Only reached for 13..23, where the low nibble minus 12 (mod 16) is exact.
    hour_minus12 = hour_bin[3:0] - 4'd12;
    valid        = (hour_bcd[7:4] <= 4'd9) && (hour_bcd[3:0] <= 4'd9) &&
                   (hour_bcd <= BCD_HOUR_MAX);
    count        = 4'd0;
    if (valid) begin
      if (hour_bin == 8'd0) begin
        count = 4'd12;
      end else if (hour_bin <= 8'd12) begin
        count = hour_bin[3:0];
      end else begin
        count = hour_minus12;
      end
    end
  end

endmodule

// File: rtl/chime_sequencer.sv
// chime_sequencer
//   Hourly chime: at hh:00:00 sounds one 1 s beep per 12-hour dial hour,
//   each beep followed by a 1 s gap (none after the last). Optional
//   single beep at hh:30:00 when CHIME_HALFHOUR_EN is defined.
//   Ports:
//     CP         - in,  1  : system clock, rising edge
//     CR         - in,  1  : async active-high reset
//     sec_tick   - in,  1  : one-cycle strobe per second
//     toll       - in,  1  : chime enable; low aborts/blocks
//     stop       - in,  1  : user silence request (level)
//     c500       - in,  1  : 500 Hz tone
//     hms        - in,  24 : BCD hh:mm:ss
//     bell       - out, 1  : buzzer drive (tone gated by BEEP)
//     busy       - out, 1  : sequence in progress
//     beeps_left - out, 4  : beeps not yet completed, incl. current
//
//   state | meaning
//   IDLE  | waiting for an hour (or half-hour) boundary
//   BEEP  | tone on for one second
//   GAP   | tone off for one second between beeps
module chime_sequencer
  import chime_sequencer_pkg::*;
(
  input  logic        CP,
  input  logic        CR,
  input  logic        sec_tick,
  input  logic        toll,
  input  logic        stop,
  input  logic        c500,
  input  logic [23:0] hms,
  output logic        bell,
  output logic        busy,
  output logic [3:0]  beeps_left
);

  state_e     state_q, state_d;
  logic [3:0] beeps_left_q, beeps_left_d;
  logic       busy_q, busy_d;

  logic [3:0] hour_count;
  logic       hour_valid;
  logic       gate_ok;
  logic       abort;

  bcd_hour_to_count u_hour (
    .hour_bcd (hms[23:16]),
    .count    (hour_count),
    .valid    (hour_valid)
  );

  always_comb begin
    state_d      = state_q;
    beeps_left_d = beeps_left_q;
    gate_ok      = sec_tick && toll && !stop && hour_valid;
    abort        = !toll || stop;

    unique case (state_q)
      IDLE: begin
        if (gate_ok && (hms[15:0] == BCD_ZERO_MS)) begin
          state_d      = BEEP;
          beeps_left_d = hour_count;
        end
`ifdef CHIME_HALFHOUR_EN
        else if (gate_ok && (hms[15:0] == BCD_HALF_MS)) begin
          state_d      = BEEP;
          beeps_left_d = 4'd1;
        end
`endif
      end
      BEEP: begin
        if (abort) begin
          state_d      = IDLE;
          beeps_left_d = 4'd0;
        end else if (sec_tick) begin
          if (beeps_left_q == 4'd1) begin
            state_d      = IDLE;
            beeps_left_d = 4'd0;
          end else begin
            state_d      = GAP;
            beeps_left_d = beeps_left_q - 4'd1;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d      = IDLE;
          beeps_left_d = 4'd0;
        end else if (sec_tick) begin
          state_d = BEEP;
        end
      end
      default: begin
        state_d      = IDLE;
        beeps_left_d = 4'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state_q      <= IDLE;
      beeps_left_q <= 4'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beeps_left_q <= beeps_left_d;
      busy_q       <= busy_d;
    end
  end

  // State is registered and CR clears it asynchronously, so bell drops
  // as soon as CR rises and never glitches on state changes.
  assign bell       = c500 & (state_q == BEEP);
  assign busy       = busy_q;
  assign beeps_left = beeps_left_q;

endmodule
